// File: rtl/pipe_regfile_fwd.sv
// Register file with an E/M/W destination-tag pipeline, operand forwarding and hazard stall.
// Define FWD_BYPASS_EN for E/M forwarding with load-use-only stalls; otherwise stall until W.
module pipe_regfile_fwd #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    input  logic              rd_en_a,
    input  logic              rd_en_b,
    input  logic              issue_valid,
    input  logic              issue_wen,
    input  logic [AW-1:0]     issue_dest,
    input  logic              issue_load,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              stall
);

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic          load;
        logic [AW-1:0] dest;
    } tag_t;

    tag_t e_q, m_q, w_q;
    tag_t e_d;
    logic e_live, m_live, w_live;
    logic [DATA_W-1:0] regs [NREG];

    assign e_live = e_q.valid & e_q.wen;
    assign m_live = m_q.valid & m_q.wen;
    assign w_live = w_q.valid & w_q.wen;

    // Only matters when NREG is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREG);
    endfunction

    function automatic logic [DATA_W-1:0] operand(input logic [AW-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!in_range(a)) begin
            v = '0;
        end
`ifdef FWD_BYPASS_EN
        else if (e_live && !e_q.load && e_q.dest == a) begin
            v = ex_data;
        end else if (m_live && m_q.dest == a) begin
            v = mem_data;
        end
`endif
        else if (w_live && w_q.dest == a) begin
            v = wb_data;
        end else begin
            v = regs[a];
        end
        return v;
    endfunction

    function automatic logic hazard(input logic en, input logic [AW-1:0] a);
`ifdef FWD_BYPASS_EN
        return en && e_live && e_q.load && (e_q.dest == a);
`else
        return en && ((e_live && e_q.dest == a) || (m_live && m_q.dest == a));
`endif
    endfunction

    assign rd_data_a = operand(rd_addr_a);
    assign rd_data_b = operand(rd_addr_b);
    assign stall     = issue_valid && (hazard(rd_en_a, rd_addr_a) || hazard(rd_en_b, rd_addr_b));

    // A stalled or flushed instruction leaves a bubble behind it in E.
    always_comb begin
        e_d = '{valid: issue_valid, wen: issue_wen, load: issue_load, dest: issue_dest};
        if (!issue_valid || stall || flush) begin
            e_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (w_live && in_range(w_q.dest)) begin
            regs[w_q.dest] <= wb_data;
        end
    end

    logic unused_load;
    assign unused_load = w_q.load;
`ifndef FWD_BYPASS_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_data, mem_data};
`endif

endmodule

// File: tb/tb_pipe_regfile_fwd.sv
// Scoreboard bench for pipe_regfile_fwd: each cycle's expected operands/stall come from an
// in-flight instruction list; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pipe_regfile_fwd;
    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int AW     = $clog2(NREG);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     rd_addr_a, rd_addr_b, issue_dest;
    logic              rd_en_a, rd_en_b, issue_valid, issue_wen, issue_load, flush;
    logic [DATA_W-1:0] ex_data, mem_data, wb_data, rd_data_a, rd_data_b;
    logic              stall;

    always #5 clk = ~clk;

    pipe_regfile_fwd #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_dest(issue_dest), .issue_load(issue_load), .flush(flush),
        .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .stall(stall)
    );

    // Reference: instructions by age (0 = issued last cycle) plus the architectural state.
    typedef struct {
        bit              valid;
        bit              wen;
        bit              load;
        int              dest;
        logic [DATA_W-1:0] val;
    } instr_t;

    typedef struct {
        bit              chk_stall;
        bit              exp_stall;
        bit              chk_a;
        logic [DATA_W-1:0] exp_a;
        bit              chk_b;
        logic [DATA_W-1:0] exp_b;
    } exp_t;

    instr_t            age [3];
    logic [DATA_W-1:0] arch [NREG];
    exp_t              sb [$];
    int                n_checks = 0;
    int                n_pass = 0;
    bit                last_stall = 0;

    function automatic bit live(input instr_t i);
        return i.valid && i.wen;
    endfunction

    // Architecturally correct value: the most recent in-flight producer, else the register.
    function automatic logic [DATA_W-1:0] latest(input int a);
        for (int k = 0; k < 3; k++) begin
            if (live(age[k]) && age[k].dest == a) return age[k].val;
        end
        return arch[a];
    endfunction

    function automatic bit blocked(input bit en, input int a);
        if (!en) return 0;
`ifdef FWD_BYPASS_EN
        return live(age[0]) && age[0].load && age[0].dest == a;
`else
        return (live(age[0]) && age[0].dest == a) || (live(age[1]) && age[1].dest == a);
`endif
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_stall) check("stall", {31'd0, stall}, {31'd0, e.exp_stall});
            if (e.chk_a) check("rd_data_a", rd_data_a, e.exp_a);
            if (e.chk_b) check("rd_data_b", rd_data_b, e.exp_b);
        end
    end

    task automatic step(input bit r, input bit iv, input bit wen, input bit ld, input int dest,
                        input logic [DATA_W-1:0] val, input bit ea, input int aa,
                        input bit eb, input int ab, input bit fl);
        exp_t e;
        bit   st;
        rst = r;  issue_valid = iv;  issue_wen = wen;  issue_load = ld;
        issue_dest = AW'(dest);  flush = fl;
        rd_en_a = ea;  rd_addr_a = AW'(aa);  rd_en_b = eb;  rd_addr_b = AW'(ab);
        // Pipeline data buses carry the producers' results; garbage where none is available.
        ex_data  = (age[0].valid && !age[0].load) ? age[0].val : $urandom();
        mem_data = age[1].valid ? age[1].val : $urandom();
        wb_data  = age[2].valid ? age[2].val : $urandom();
        st = iv && (blocked(ea, aa) || blocked(eb, ab));
        e.chk_stall = !r;
        e.exp_stall = st;
        e.chk_a = !r && iv && ea && !st;
        e.exp_a = latest(aa);
        e.chk_b = !r && iv && eb && !st;
        e.exp_b = latest(ab);
        sb.push_back(e);
        last_stall = st;
        if (r) begin
            for (int k = 0; k < 3; k++) age[k].valid = 0;
            for (int i = 0; i < NREG; i++) arch[i] = '0;
        end else begin
            if (live(age[2])) arch[age[2].dest] = age[2].val;
            age[2] = age[1];
            age[1] = age[0];
            age[0] = '{valid: iv && !st && !fl, wen: wen, load: ld, dest: dest, val: val};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    // Keep a consumer in D until it stops stalling (bounded).
    task automatic read_hold(input bit ea, input int aa, input bit eb, input int ab);
        step(0, 1, 0, 0, 0, '0, ea, aa, eb, ab, 0);
        for (int k = 0; k < 4 && last_stall; k++) step(0, 1, 0, 0, 0, '0, ea, aa, eb, ab, 0);
    endtask

    initial begin
        bit r, iv, wen, ld, ea, eb, fl;
        int dest, aa, ab;
        logic [DATA_W-1:0] val;
        for (int k = 0; k < 3; k++) age[k] = '{valid: 0, wen: 0, load: 0, dest: 0, val: '0};
        for (int i = 0; i < NREG; i++) arch[i] = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        // Post-reset: everything reads zero, no stall.
        step(0, 1, 0, 0, 0, '0, 1, 5, 1, 9, 0);
        // Back-to-back ALU dependency.
        step(0, 1, 1, 0, 3, 32'h0000_00AA, 0, 0, 0, 0, 0);
        read_hold(1, 3, 0, 0);
        // Load-use.
        step(0, 1, 1, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0);
        read_hold(1, 5, 0, 0);
        // Same register in M (older) and E (younger).
        step(0, 1, 1, 0, 2, 32'h22, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2, 32'h11, 0, 0, 0, 0, 0);
        read_hold(1, 2, 1, 2);
        // Flushed producer never writes.
        step(0, 1, 1, 0, 7, 32'hBEEF, 0, 0, 0, 0, 1);
        idle(); idle(); idle();
        read_hold(1, 7, 0, 0);
        // Reset while a write is one edge away from W.
        step(0, 1, 1, 0, 4, 32'hDEAD, 0, 0, 0, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        idle(); idle();
        read_hold(1, 4, 0, 0);
        // Disabled source matching a load in E.
        step(0, 1, 1, 1, 6, 32'h600D, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, '0, 1, 1, 0, 6, 0);
        // Randomized traffic over a few hot registers; D is held while stalled.
        iv = 0; wen = 0; ld = 0; dest = 0; val = '0; ea = 0; aa = 0; eb = 0; ab = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!last_stall) begin
                iv   = $urandom_range(0, 3) != 0;
                wen  = $urandom_range(0, 3) != 0;
                ld   = $urandom_range(0, 2) == 0;
                dest = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 3);
                val  = $urandom();
                ea   = $urandom_range(0, 1);
                eb   = $urandom_range(0, 1);
                aa   = $urandom_range(0, 3);
                ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 3);
            end
            r  = $urandom_range(0, 99) == 0;
            fl = $urandom_range(0, 7) == 0;
            step(r, iv, wen, ld, dest, val, ea, aa, eb, ab, fl);
        end
        idle();
        idle();
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_regfile_fwd.md
PIPE_REGFILE_FWD -- requirements
Module: pipe_regfile_fwd

Interface
REQ-001 Parameter DATA_W, default 32: register and data-bus width in bits.
REQ-002 Parameter NREG, default 16: number of architectural registers; AW = $clog2(NREG) is derived and SHALL NOT be overridden.
REQ-003 Port list, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_a / rd_addr_b  in  AW each  decode-stage (D) source register indices.
- rd_en_a / rd_en_b  in  1 each  source actually used; an unused source never causes a stall.
- issue_valid  in  1  instruction in D requests to advance to E.
- issue_wen  in  1  instruction in D writes a register.
- issue_dest  in  AW  its destination index.
- issue_load  in  1  its result comes from memory and is available only in M.
- flush  in  1  branch taken in E; kills the D-to-E transfer this cycle.
- ex_data / mem_data / wb_data  in  DATA_W each  result of the instruction currently in E / M / W.
- rd_data_a / rd_data_b  out  DATA_W each  forwarded operand values for D.
- stall  out  1  combinational hold request to fetch and decode.

Function
REQ-004 The block SHALL keep an internal tag pipeline E, M, W; each tag holds {valid, wen, load, dest}.
- Every cycle: M <= E, W <= M unconditionally.
- E <= D-tag only when issue_valid=1, stall=0 and flush=0; otherwise E <= bubble (valid=0).
REQ-005 A tag is live only when valid=1 and wen=1. Only live tags participate in hazard and forwarding.
REQ-006 Writeback: when the W tag is live, the register array SHALL write regs[W.dest] <= wb_data at the clock edge.
REQ-007 Reads SHALL be write-through: a read matching a live W dest returns wb_data in the same cycle.
REQ-008 Forward priority per source, highest first:
- live E match and E.load=0 -> ex_data
- live M match -> mem_data
- live W match -> wb_data
- otherwise regs[addr]
REQ-009 Load-use stall: stall SHALL be 1 when issue_valid=1 and an enabled source matches a live E tag with E.load=1.
REQ-010 During a stall, D is held externally; the block inserts a bubble into E, so the stall lasts exactly 1 cycle.
REQ-011 When flush and a stall condition coincide, flush wins: E <= bubble and stall output is still driven per REQ-009. No tag other than the D-to-E transfer is killed.
REQ-012 Both sources matching the same dest SHALL receive identical forwarded values.
REQ-013 Out-of-range indices (>= NREG, when NREG is not a power of two) SHALL read 0 and SHALL NOT write.
REQ-014 rd_data_a/b and stall are combinational from inputs and state; there is no added read latency.

Reset
REQ-015 With rst=1 at a rising edge: all E/M/W tags SHALL be set to valid=0 and all registers SHALL be set to 0.
REQ-016 While rst=1, no register write occurs regardless of wb_data.
REQ-017 After reset deassertion: stall=0 and rd_data_a/b=0 for any address, until the first writeback.
REQ-018 Reset asserted mid-stall or mid-flush SHALL discard all in-flight tags; no pending write completes.

Configuration
REQ-019 Macro FWD_BYPASS_EN, when defined, SHALL enable REQ-008 and REQ-009 as written.
REQ-020 When FWD_BYPASS_EN is undefined:
- No E or M forwarding; only the REQ-007 write-through remains.
- stall=1 whenever issue_valid=1 and an enabled source matches any live E or M tag, load or not.
- The stall repeats each cycle until the producer reaches W.

Verification
REQ-021 Back-to-back ALU dependency: issue r3<=ALU, then read r3 next cycle with ex_data=0x0000_00AA -> rd_data_a=0xAA, stall=0 (bypass on). Without the macro: stall=1 for 2 cycles, then 0xAA via W.
REQ-022 Load-use: issue load r5, next cycle read r5 -> stall=1 for exactly 1 cycle; next cycle rd_data_a=mem_data=0x1234_5678.
REQ-023 Priority: r2 live in both E (ex_data=0x11) and M (mem_data=0x22) -> rd_data_a=rd_data_b=0x11.
REQ-024 Flush: issue r7 with flush=1 -> no write to r7 after 3 cycles; read r7 returns its prior value 0x0.
REQ-025 Reset mid-pipeline: write 0xDEAD to r4 reaching W, rst pulse one cycle earlier -> r4 reads 0 and stall=0.
REQ-026 Unused source: rd_en_b=0 with rd_addr_b matching a live load in E -> stall=0.
